// File: rtl/ual_issue_ctrl.sv
// ual_issue_ctrl: command FIFO and issue sequencer placed in front of the
// combinational ual ALU.
//   Commands {in0, in1, sel} enter through a valid/ready port and are stored
//   in a DEPTH-entry FIFO. One command at a time is popped onto registered
//   ual_in0/ual_in1/ual_sel. One cycle later ual_out is captured and offered
//   downstream on the res_valid/res_ready port.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_in0, cmd_in1, cmd_sel   command payload
//   ual_in0, ual_in1, ual_sel   registered operands/select to ual
//   ual_out                     combinational ual result
//   res_valid/res_ready         result handshake
//   res_data, res_sel           captured result and the sel that produced it
//   op_count                    results accepted downstream (wraps)
module ual_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_in0,
  input  logic [3:0]       cmd_in1,
  input  logic [2:0]       cmd_sel,
  output logic [3:0]       ual_in0,
  output logic [3:0]       ual_in1,
  output logic [2:0]       ual_sel,
  input  logic [7:0]       ual_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_sel,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [3:0] in0;
    logic [3:0] in1;
    logic [2:0] sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  // Ready reflects occupancy only, so a pop in the same cycle never frees
  // a slot early.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // The head is only taken while the issue slot is free.
  assign pop       = (state == IDLE) && !empty;

  // Payload storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{in0: cmd_in0, in1: cmd_in1, sel: cmd_sel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ual inputs move only on a pop, so they stay stable through ISSUE and
  // ual_out has a full cycle to settle before it is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ual_in0   <= '0;
      ual_in1   <= '0;
      ual_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sel   <= '0;
      op_count  <= '0;
    end else begin
      if (pop) begin
        ual_in0 <= mem[rd_ptr].in0;
        ual_in1 <= mem[rd_ptr].in1;
        ual_sel <= mem[rd_ptr].sel;
      end
      if (state == ISSUE) begin
        res_data  <= ual_out;
        res_sel   <= ual_sel;
        res_valid <= 1'b1;
      end
      if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule
